// File: rtl/pinball_pkg.sv
// Shared constants and types for the pinball collision logic.
// Pair IDs index the per-pair channel vectors so new pairs (e.g. holes) slot in cleanly.
package pinball_pkg;

    localparam int COLLISION_COOLDOWN_DEFAULT = 3;

    // Bits needed to hold 0..frames, never narrower than one bit.
    function automatic int cooldownWidth(input int frames);
        return (frames < 1) ? 1 : $clog2(frames + 1);
    endfunction

    localparam int COOLDOWN_W = cooldownWidth(COLLISION_COOLDOWN_DEFAULT);

    typedef logic [COOLDOWN_W-1:0] cooldown_t;

    typedef enum logic [0:0] {
        PAIR_BORDERS = 1'b0,
        PAIR_FLIPPER = 1'b1
    } pair_id_e;

    localparam int NUM_PAIRS = 2;

endpackage

// File: rtl/collision_channel.sv
// One collision pair: fires a registered single-cycle pulse at most once per frame,
// then stays quiet for COOLDOWN_FRAMES frame starts (frozen while paused).
module collision_channel
    import pinball_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = COLLISION_COOLDOWN_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic overlap,
    input  logic startOfFrame,
    input  logic pause,
    output logic pulse
);

    localparam int CD_W = cooldownWidth(COOLDOWN_FRAMES);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

    logic            fired_q, fired_d;
    logic [CD_W-1:0] cooldown_q, cooldown_d;
    logic            pulse_q, pulse_d;
    logic            fire;

    // Frame start always wins over an overlap in the same cycle.
    always_comb begin
        fire       = overlap && !fired_q && (cooldown_q == '0) && !pause && !startOfFrame;
        pulse_d    = fire;
        fired_d    = fired_q;
        cooldown_d = cooldown_q;
        if (startOfFrame) begin
            fired_d = 1'b0;
            if (!pause && (cooldown_q != '0)) begin
                cooldown_d = cooldown_q - CD_W'(1);
            end
        end else if (fire) begin
            fired_d    = 1'b1;
            cooldown_d = CD_LOAD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fired_q    <= 1'b0;
            cooldown_q <= '0;
            pulse_q    <= 1'b0;
        end else begin
            fired_q    <= fired_d;
            cooldown_q <= cooldown_d;
            pulse_q    <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/collision_detector.sv
// Pixel-rate collision arbiter feeding the smiley block: per-pair pulse channels,
// a saturating flipper-hit counter and a one-frame-delayed "had collision" flag.
module collision_detector
    import pinball_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = COLLISION_COOLDOWN_DEFAULT,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startOfFrame,
    input  logic             pause,
    input  logic             draw_smiley,
    input  logic             draw_borders,
    input  logic             draw_flipper,
    output logic             collisionSmileyBorders,
    output logic             collisionSmileyFlipper,
    output logic [CNT_W-1:0] flipperHits,
    output logic             frameHadCollision
);

    localparam logic [CNT_W-1:0] HITS_MAX = '1;

    logic [NUM_PAIRS-1:0] overlap;
    logic [NUM_PAIRS-1:0] pulse;
    logic                 anyPulse;

    logic [CNT_W-1:0] hits_q, hits_d;
    logic             sticky_q, sticky_d;
    logic             frameHad_q, frameHad_d;

    assign overlap[PAIR_BORDERS] = draw_smiley & draw_borders;
    assign overlap[PAIR_FLIPPER] = draw_smiley & draw_flipper;

    for (genvar p = 0; p < NUM_PAIRS; p++) begin : gen_chan
        collision_channel #(
            .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .overlap     (overlap[p]),
            .startOfFrame(startOfFrame),
            .pause       (pause),
            .pulse       (pulse[p])
        );
    end

    assign anyPulse = |pulse;

    // A pulse coinciding with frame start belongs to the new frame's sticky bit.
    always_comb begin
        hits_d     = hits_q;
        sticky_d   = sticky_q | anyPulse;
        frameHad_d = frameHad_q;
        if (pulse[PAIR_FLIPPER] && (hits_q != HITS_MAX)) begin
            hits_d = hits_q + CNT_W'(1);
        end
        if (startOfFrame) begin
            frameHad_d = sticky_q;
            sticky_d   = anyPulse;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hits_q     <= '0;
            sticky_q   <= 1'b0;
            frameHad_q <= 1'b0;
        end else begin
            hits_q     <= hits_d;
            sticky_q   <= sticky_d;
            frameHad_q <= frameHad_d;
        end
    end

    assign collisionSmileyBorders = pulse[PAIR_BORDERS];
    assign collisionSmileyFlipper = pulse[PAIR_FLIPPER];
    assign flipperHits            = hits_q;
    assign frameHadCollision      = frameHad_q;

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector: a frame-level reference model checked every
// cycle, plus directed scenarios with literal expectations. A second instance uses CNT_W=2.
module tb_collision_detector;

    localparam int COOL = 3;

    logic clk;
    logic reset;
    logic startOfFrame;
    logic pause;
    logic drawSmiley;
    logic drawBorders;
    logic drawFlipper;

    logic        bordA, flipA, frameHadA;
    logic [15:0] hitsA;
    logic        bordB, flipB, frameHadB;
    logic [1:0]  hitsB;

    int errors = 0;
    int checks = 0;
    bit checkEn = 0;
    int bordCnt = 0;
    int flipCnt = 0;

    // Reference model state: frames elapsed since a pair last fired, counted only on unpaused frame starts.
    bit expPulse[2];
    bit firedFrame[2];
    int framesSince[2];
    int expHitsA;
    int expHitsB;
    bit expSticky;
    bit expFrameHad;
    bit ov[2];
    bit oldFlip;
    bit oldAny;
    bit fireNow;

    collision_detector #(.COOLDOWN_FRAMES(COOL), .CNT_W(16)) dutA (
        .clk                   (clk),
        .reset                 (reset),
        .startOfFrame          (startOfFrame),
        .pause                 (pause),
        .draw_smiley           (drawSmiley),
        .draw_borders          (drawBorders),
        .draw_flipper          (drawFlipper),
        .collisionSmileyBorders(bordA),
        .collisionSmileyFlipper(flipA),
        .flipperHits           (hitsA),
        .frameHadCollision     (frameHadA)
    );

    collision_detector #(.COOLDOWN_FRAMES(COOL), .CNT_W(2)) dutB (
        .clk                   (clk),
        .reset                 (reset),
        .startOfFrame          (startOfFrame),
        .pause                 (pause),
        .draw_smiley           (drawSmiley),
        .draw_borders          (drawBorders),
        .draw_flipper          (drawFlipper),
        .collisionSmileyBorders(bordB),
        .collisionSmileyFlipper(flipB),
        .flipperHits           (hitsB),
        .frameHadCollision     (frameHadB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic sof, input logic ps, input logic s,
                                 input logic b, input logic f);
        @(negedge clk);
        if (bordA) bordCnt++;
        if (flipA) flipCnt++;
        startOfFrame = sof;
        pause        = ps;
        drawSmiley   = s;
        drawBorders  = b;
        drawFlipper  = f;
    endtask

    task automatic runFrame(input logic ps, input logic b, input logic f);
        applyStimulus(1'b1, ps, 1'b0, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, ps, 1'b0, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, ps, 1'b1, b, f);
        repeat (3) applyStimulus(1'b0, ps, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clearCounts();
        bordCnt = 0;
        flipCnt = 0;
    endtask

    // Model: outputs visible after each rising edge, derived from frame-level rules.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                expPulse[p]    = 1'b0;
                firedFrame[p]  = 1'b0;
                framesSince[p] = COOL;
            end
            expHitsA    = 0;
            expHitsB    = 0;
            expSticky   = 1'b0;
            expFrameHad = 1'b0;
        end else begin
            oldFlip = expPulse[1];
            oldAny  = expPulse[0] | expPulse[1];
            ov[0]   = drawSmiley & drawBorders;
            ov[1]   = drawSmiley & drawFlipper;
            for (int p = 0; p < 2; p++) begin
                fireNow = ov[p] && !firedFrame[p] && (framesSince[p] >= COOL)
                          && !pause && !startOfFrame;
                expPulse[p] = fireNow;
                if (startOfFrame) begin
                    firedFrame[p] = 1'b0;
                    if (!pause && framesSince[p] < COOL) framesSince[p]++;
                end
                if (fireNow) begin
                    firedFrame[p]  = 1'b1;
                    framesSince[p] = 0;
                end
            end
            if (oldFlip) begin
                expHitsA = (expHitsA < 65535) ? expHitsA + 1 : 65535;
                expHitsB = (expHitsB < 3) ? expHitsB + 1 : 3;
            end
            if (startOfFrame) begin
                expFrameHad = expSticky;
                expSticky   = oldAny;
            end else begin
                expSticky = expSticky | oldAny;
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cyc_bordersA", bordA, expPulse[0]);
            checkOutput("cyc_flipperA", flipA, expPulse[1]);
            checkOutput("cyc_hitsA", hitsA, expHitsA);
            checkOutput("cyc_frameHadA", frameHadA, expFrameHad);
            checkOutput("cyc_flipperB", flipB, expPulse[1]);
            checkOutput("cyc_hitsB", hitsB, expHitsB);
        end
    end

    initial begin
        reset        = 1'b1;
        startOfFrame = 1'b0;
        pause        = 1'b0;
        drawSmiley   = 1'b0;
        drawBorders  = 1'b0;
        drawFlipper  = 1'b0;
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        checkEn = 1'b1;

        checkOutput("rst_borders", bordA, 0);
        checkOutput("rst_flipper", flipA, 0);
        checkOutput("rst_hits", hitsA, 0);
        checkOutput("rst_frameHad", frameHadA, 0);

        // Sustained border overlap gives exactly one pulse, one clock after the first overlap.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clearCounts();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("s1_first_pulse", bordA, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("s1_pulse_ends", bordA, 0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s1_border_count", bordCnt, 1);
        checkOutput("s1_flipper_count", flipCnt, 0);

        // Flipper overlap in four consecutive frames: fires in frames 1 and 4 only.
        clearCounts();
        repeat (4) runFrame(1'b0, 1'b0, 1'b1);
        checkOutput("s2_flipper_count", flipCnt, 2);
        checkOutput("s2_hitsA", hitsA, 2);
        checkOutput("s2_model_hits", expHitsA, 2);

        // Overlap in the frame-start cycle is ignored; one cycle later it fires.
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("s3_sof_ignored", bordA, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s3_next_cycle_fires", bordA, 1);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s3_border_count", bordCnt, 1);

        // Simultaneous border and flipper hits, then the frame-level flag.
        repeat (3) runFrame(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s4_both_borders", bordA, 1);
        checkOutput("s4_both_flipper", flipA, 1);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s4_frameHad_set", frameHadA, 1);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s4_frameHad_clear", frameHadA, 0);

        // Pause freezes cooldown; after unpause two more frames stay suppressed.
        runFrame(1'b0, 1'b0, 1'b0);
        clearCounts();
        runFrame(1'b0, 1'b0, 1'b1);
        checkOutput("s5_initial_fire", flipCnt, 1);
        repeat (4) runFrame(1'b1, 1'b0, 1'b1);
        checkOutput("s5_paused_no_pulse", flipCnt, 1);
        repeat (2) runFrame(1'b0, 1'b0, 1'b1);
        checkOutput("s5_still_cooling", flipCnt, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("s5_pulse_survives_pause", flipA, 1);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s5_final_count", flipCnt, 2);

        // Fresh reset, then five spaced flipper hits saturate the 2-bit counter.
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            runFrame(1'b0, 1'b0, 1'b1);
            repeat (2) runFrame(1'b0, 1'b0, 1'b0);
        end
        checkOutput("s6_hitsB_saturated", hitsB, 3);
        checkOutput("s6_hitsA", hitsA, 5);

        // Reset mid-frame with a pulse about to be registered.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        #2 reset = 1'b1;
        @(negedge clk);
        checkOutput("s6_rst_borders", bordA, 0);
        checkOutput("s6_rst_flipper", flipA, 0);
        checkOutput("s6_rst_hitsA", hitsA, 0);
        checkOutput("s6_rst_hitsB", hitsB, 0);
        checkOutput("s6_rst_frameHad", frameHadA, 0);
        reset       = 1'b0;
        drawSmiley  = 1'b0;
        drawBorders = 1'b0;
        drawFlipper = 1'b0;
        @(negedge clk);
        checkOutput("s6_no_pending_borders", bordA, 0);
        checkOutput("s6_no_pending_flipper", flipA, 0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/collision_detector.md
Name: collision_detector

Overview:
- Pixel-rate collision arbiter that sits directly upstream of the smiley block and drives its collisionSmileyBorders and collisionSmileyFlipper inputs.
- Compares the per-pixel draw requests of the smiley, the borders and the flipper during the frame scan.
- Emits at most one registered single-cycle collision pulse per object pair per frame.
- Applies a per-pair frame cooldown so a ball still overlapping an object does not re-bounce every frame, and keeps a saturating hit counter for scoring.

Parameters:
- COOLDOWN_FRAMES, 3: frames during which a pair's pulse is suppressed after that pair fires.
- CNT_W, 16: width of the saturating flipper-hit counter.

Ports:
- clk  in  1  pixel clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset; also clears all state.
- startOfFrame  in  1  single-cycle pulse at the start of vertical blanking.
- pause  in  1  level; freezes detection and cooldowns.
- draw_smiley  in  1  smiley pixel is opaque at the current PixelX/PixelY.
- draw_borders  in  1  border pixel is opaque at the current pixel.
- draw_flipper  in  1  flipper pixel is opaque at the current pixel.
- collisionSmileyBorders  out  1  single-cycle pulse, smiley/border hit.
- collisionSmileyFlipper  out  1  single-cycle pulse, smiley/flipper hit.
- flipperHits  out  CNT_W  saturating count of flipper pulses since reset.
- frameHadCollision  out  1  level: high for the whole frame after any pulse in the previous frame.

Behaviour:
- Reset:
  - Both collision outputs are 0; flipperHits is 0; frameHadCollision is 0.
  - Both per-frame flags and both cooldown counters are 0.
- Each pair is handled by an identical channel: overlap = draw_smiley & draw_<obj>.
- Channel state:
  - firedThisFrame, 1 bit.
  - cooldown, ceil(log2(COOLDOWN_FRAMES+1)) bits.
- Fire condition in cycle t: overlap & !firedThisFrame & (cooldown==0) & !pause & !startOfFrame.
- Fire response:
  - Registered pulse = 1 in cycle t+1 only; latency is exactly 1 clk.
  - firedThisFrame is set.
  - cooldown is loaded with COOLDOWN_FRAMES.
- Further overlaps in the same frame produce no pulse.
- On startOfFrame:
  - firedThisFrame is cleared.
  - If !pause and cooldown>0, cooldown decrements by 1.
  - Overlap in the startOfFrame cycle itself is ignored, because clear wins.
- Timing with COOLDOWN_FRAMES=3:
  - A pair that fires in frame N is suppressed in frames N+1 and N+2.
  - The first decrement happens at the start of frame N+1, counting 3→2→1→0.
  - The pair may fire again in frame N+3.
- Pause high:
  - Pulses are suppressed.
  - Flags still clear at startOfFrame.
  - Cooldowns hold their value.
  - A pause rising mid-frame does not cancel a pulse already registered.
- Simultaneous events:
  - Border and flipper overlap in the same cycle fire both pulses in the same cycle; the channels are independent.
- flipperHits increments by 1 on each collisionSmileyFlipper pulse and saturates at 2^CNT_W−1.
- frameHadCollision:
  - An internal sticky bit sets on any pulse.
  - At startOfFrame the sticky value is copied to frameHadCollision and the sticky bit is cleared; if a pulse and startOfFrame coincide, the pulse sets the new sticky bit.
- Reset asserted mid-frame or mid-cooldown returns everything to reset values immediately, with no pending pulse.

Decomposition:
- Package pinball_pkg holds:
  - COLLISION_COOLDOWN_DEFAULT.
  - The typedef for the cooldown counter width.
  - An enum of collision pair IDs (PAIR_BORDERS, PAIR_FLIPPER) for future pairs such as holes.
- Sub-module collision_channel, instantiated once per pair:
  - Inputs: clk, reset, overlap, startOfFrame, pause.
  - Output: pulse.
  - Contains the flag, the cooldown counter and the output register.
- The top level contains the AND gates, the counter and the frameHadCollision logic.

Test Plan:
- Reset, then draw_smiley=draw_borders=1 for 5 consecutive cycles mid-frame → collisionSmileyBorders=1 for exactly one cycle, one clk after the first overlap cycle; flipper output stays 0.
- Flipper overlap in frames 1, 2, 3, 4 with COOLDOWN_FRAMES=3 → pulses in frame 1 and frame 4 only; flipperHits=2.
- Overlap asserted only in the startOfFrame cycle → no pulse; the same overlap one cycle later → pulse.
- Border and flipper overlap in the same cycle → both pulses in the same cycle; frameHadCollision=1 after the next startOfFrame, and 0 after the following startOfFrame with no hits.
- pause=1 across 4 frames following a fire with overlap present → no pulses, cooldown frozen; after pause=0, suppression lasts the remaining 2 frames.
- CNT_W=2 with 5 flipper hits spaced past the cooldown → flipperHits saturates at 3; asserting reset mid-frame → all outputs 0 next cycle.
